// File: rtl/shake256_squeeze.sv
// SHAKE256 squeeze stage: copies up to out_len bytes out of the Keccak rate
// block, one byte per cycle, and asks an external Keccak-f[1600] core for a
// fresh state when the 136-byte rate block runs dry. The returned state and
// position let consecutive squeeze calls chain.
module shake256_squeeze #(
    parameter int out_len = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rtr,
    input  logic [1599:0]        linear_state_s_in,
    input  logic [31:0]          state_pos_in,
    input  logic [63:0]          outlen,
    output logic [out_len*8-1:0] linear_out,
    output logic [1599:0]        linear_state_s_out,
    output logic [31:0]          state_pos_out,
    output logic                 rts,
    output logic                 perm_rtr,
    output logic [1599:0]        perm_linear_s_out,
    input  logic [1599:0]        perm_linear_s_in,
    input  logic                 perm_rts
);

    localparam int          SHAKE256_RATE = 136;
    localparam logic [31:0] RATE_POS      = 32'(SHAKE256_RATE);
    localparam int          CNT_W         = $clog2(out_len + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_COPY,
        S_PERM_REQ,
        S_PERM_WAIT,
        S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [1599:0]        keccak_q;
    logic [31:0]          pos_q;
    logic [CNT_W-1:0]     rem_q;
    logic [CNT_W-1:0]     j_q;
    logic [out_len*8-1:0] out_q;
    logic [1599:0]        perm_q;

    // Byte offsets into the state (pos < 136 while copying) and the output.
    logic [10:0]          rd_idx;
    logic [CNT_W+2:0]     wr_idx;
    logic [CNT_W-1:0]     rem_start;
    logic [31:0]          pos_start;

    assign rd_idx    = {pos_q[7:0], 3'b000};
    assign wr_idx    = {j_q, 3'b000};
    assign rem_start = (outlen > 64'(out_len)) ? CNT_W'(out_len) : outlen[CNT_W-1:0];
    assign pos_start = (state_pos_in > RATE_POS) ? RATE_POS : state_pos_in;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential logic uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: walk CHECK -> COPY/PERM -> DONE for one squeeze call.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (rtr) state_d = S_CHECK;
            S_CHECK: begin
                if (rem_q == '0)          state_d = S_DONE;
                else if (pos_q == RATE_POS) state_d = S_PERM_REQ;
                else                      state_d = S_COPY;
            end
            S_COPY: begin
                if (rem_q == CNT_W'(1))          state_d = S_DONE;
                else if (pos_q == RATE_POS - 1)  state_d = S_CHECK;
            end
            S_PERM_REQ:  state_d = S_PERM_WAIT;
            S_PERM_WAIT: if (perm_rts) state_d = S_COPY;
            S_DONE:      state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Output decode: single-cycle pulses tied to their states.
    always_comb begin
        rts      = (state_q == S_DONE);
        perm_rtr = (state_q == S_PERM_REQ);
    end

    // Datapath: latch inputs, copy bytes, take the permuted state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the wide state/output registers are plain flops, not a
            // memory, so clearing them on reset is legal and required here.
            keccak_q <= '0;
            pos_q    <= '0;
            rem_q    <= '0;
            j_q      <= '0;
            out_q    <= '0;
            perm_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rtr) begin
                        keccak_q <= linear_state_s_in;
                        pos_q    <= pos_start;
                        rem_q    <= rem_start;
                        j_q      <= '0;
                        out_q    <= '0;
                    end
                end
                S_CHECK: begin
                    // Snapshot the state for the core just before requesting.
                    if (rem_q != '0 && pos_q == RATE_POS) perm_q <= keccak_q;
                end
                S_COPY: begin
                    out_q[wr_idx +: 8] <= keccak_q[rd_idx +: 8];
                    pos_q              <= pos_q + 32'd1;
                    j_q                <= j_q + CNT_W'(1);
                    rem_q              <= rem_q - CNT_W'(1);
                end
                S_PERM_WAIT: begin
                    if (perm_rts) begin
                        keccak_q <= perm_linear_s_in;
                        pos_q    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign linear_out         = out_q;
    assign linear_state_s_out = keccak_q;
    assign state_pos_out      = pos_q;
    assign perm_linear_s_out  = perm_q;

endmodule

// File: tb/tb_shake256_squeeze.sv
// Self-checking bench for shake256_squeeze: table vectors, random calls
// against a byte-level squeeze model, plus rtr-glitch and reset-abort cases.
module tb_shake256_squeeze;

    localparam int OUT_LEN = 32;

    logic                 clock;
    logic                 reset;
    logic                 rtr;
    logic [1599:0]        ls_in;
    logic [31:0]          pos_in;
    logic [63:0]          outlen_in;
    logic [OUT_LEN*8-1:0] lout;
    logic [1599:0]        ls_out;
    logic [31:0]          pos_out;
    logic                 rts;
    logic                 perm_rtr;
    logic [1599:0]        perm_s_out;
    logic [1599:0]        perm_s_in;
    logic                 perm_rts;

    int n_tests = 0;
    int n_fail  = 0;

    // Permutation core model controls and observations.
    int            core_delay = 0;
    logic [1599:0] perm_val   = '0;
    int            perm_cnt   = 0;
    logic [1599:0] perm_cap   = '0;

    shake256_squeeze #(.out_len(OUT_LEN)) dut (
        .clock              (clock),
        .reset              (reset),
        .rtr                (rtr),
        .linear_state_s_in  (ls_in),
        .state_pos_in       (pos_in),
        .outlen             (outlen_in),
        .linear_out         (lout),
        .linear_state_s_out (ls_out),
        .state_pos_out      (pos_out),
        .rts                (rts),
        .perm_rtr           (perm_rtr),
        .perm_linear_s_out  (perm_s_out),
        .perm_linear_s_in   (perm_s_in),
        .perm_rts           (perm_rts)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Permutation core: sees a request, waits core_delay extra edges, then
    // presents perm_val with a one-cycle perm_rts.
    initial begin
        perm_rts  = 1'b0;
        perm_s_in = '0;
        forever begin
            @(negedge clock);
            if (perm_rtr === 1'b1) begin
                perm_cnt++;
                perm_cap = perm_s_out;
                @(posedge clock);
                repeat (core_delay) @(posedge clock);
                #1;
                perm_rts  = 1'b1;
                perm_s_in = perm_val;
                @(posedge clock);
                #1 perm_rts = 1'b0;
            end
        end
    end

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_wide(input string nm, input logic [1599:0] act, input logic [1599:0] exp);
        int idx;
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            idx = -1;
            for (int k = 0; k < 200; k++)
                if (idx < 0 && act[8*k +: 8] !== exp[8*k +: 8]) idx = k;
            if (idx < 0) idx = 0;
            $display("FAIL %s: byte %0d got %h expected %h", nm, idx,
                     act[8*idx +: 8], exp[8*idx +: 8]);
        end
    endtask

    function automatic logic [1599:0] pattern_state();
        logic [1599:0] r;
        for (int k = 0; k < 200; k++) r[8*k +: 8] = 8'(k);
        return r;
    endfunction

    function automatic logic [1599:0] fill_state(input logic [7:0] b);
        logic [1599:0] r;
        for (int k = 0; k < 200; k++) r[8*k +: 8] = b;
        return r;
    endfunction

    function automatic logic [1599:0] random_state();
        logic [1599:0] r;
        for (int k = 0; k < 50; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    // Squeeze reference: walk the rate block byte by byte, swapping in the
    // permuted state whenever a byte is needed and the block is exhausted.
    task automatic model(input logic [1599:0] st, input logic [31:0] pin,
                         input logic [63:0] olen, input logic [1599:0] pv,
                         output logic [255:0] eo, output logic [1599:0] es,
                         output logic [31:0] ep, output int np, output bit at_start,
                         output int n, output logic [1599:0] pre);
        byte unsigned sb[200];
        int pos;
        for (int k = 0; k < 200; k++) sb[k] = st[8*k +: 8];
        pos      = (pin > 32'd136) ? 136 : int'(pin);
        n        = (olen > 64'(OUT_LEN)) ? OUT_LEN : int'(olen);
        eo       = '0;
        np       = 0;
        at_start = 1'b0;
        pre      = st;
        for (int i = 0; i < n; i++) begin
            if (pos == 136) begin
                for (int k = 0; k < 200; k++) pre[8*k +: 8] = sb[k];
                for (int k = 0; k < 200; k++) sb[k] = pv[8*k +: 8];
                pos = 0;
                np++;
                if (i == 0) at_start = 1'b1;
            end
            eo[8*i +: 8] = sb[pos];
            pos++;
        end
        for (int k = 0; k < 200; k++) es[8*k +: 8] = sb[k];
        ep = 32'(pos);
    endtask

    // One squeeze call; glitch > 0 re-pulses rtr (with other inputs) in that cycle.
    task automatic run_call(input string nm, input logic [1599:0] st, input logic [31:0] pin,
                            input logic [63:0] olen, input int d, input logic [1599:0] pv,
                            input int glitch);
        logic [255:0]  eo;
        logic [1599:0] es, pre;
        logic [31:0]   ep;
        int np, n, base, cyc, exp_lat;
        bit at_start, got;
        model(st, pin, olen, pv, eo, es, ep, np, at_start, n, pre);
        core_delay = d;
        perm_val   = pv;
        base       = perm_cnt;
        @(posedge clock);
        #1;
        ls_in     = st;
        pos_in    = pin;
        outlen_in = olen;
        rtr       = 1'b1;
        @(posedge clock);   // edge 0: rtr sampled
        #1 rtr = 1'b0;
        cyc = 1;
        got = 1'b0;
        while (cyc < 2000 && !got) begin
            if (glitch != 0 && cyc == glitch) begin
                rtr       = 1'b1;
                pos_in    = 32'd7;
                outlen_in = 64'd3;
                ls_in     = ~st;
            end else if (glitch != 0 && cyc == glitch + 1) begin
                rtr = 1'b0;
            end
            @(negedge clock);
            if (rts === 1'b1) got = 1'b1;
            else begin
                @(posedge clock);
                #1;
                cyc++;
            end
        end
        rtr = 1'b0;
        exp_lat = n + 2 + ((np > 0) ? (d + 1 + (at_start ? 1 : 2)) : 0);
        check({nm, " rts_cycle"}, got ? 256'(cyc) : '1, 256'(exp_lat));
        check({nm, " linear_out"}, lout, eo);
        check({nm, " pos_out"}, 256'(pos_out), 256'(ep));
        check_wide({nm, " state_out"}, ls_out, es);
        check({nm, " perm_count"}, 256'(perm_cnt - base), 256'(np));
        if (np > 0) check_wide({nm, " perm_s_out"}, perm_cap, pre);
        @(posedge clock);
        #1 check({nm, " rts_pulse"}, 256'(rts), 256'(0));
        repeat (2) @(posedge clock);
        #1 check({nm, " out_hold"}, lout, eo);
    endtask

    typedef struct {
        logic [31:0] pin;
        logic [63:0] olen;
        int          d;
        logic [31:0] exp_pos;
        int          exp_perms;
    } vec_t;

    initial begin
        vec_t          vecs[9];
        logic [1599:0] pat, a5;
        int            base, seen;
        logic [31:0]   rp;
        logic [63:0]   ro;

        pat = pattern_state();
        a5  = fill_state(8'hA5);
        vecs[0] = '{32'd0,   64'd32,   0,  32'd32,  0};
        vecs[1] = '{32'd130, 64'd10,   23, 32'd4,   1};
        vecs[2] = '{32'd136, 64'd1,    3,  32'd1,   1};
        vecs[3] = '{32'd50,  64'd0,    0,  32'd50,  0};
        vecs[4] = '{32'd0,   64'd1000, 0,  32'd32,  0};
        vecs[5] = '{32'd104, 64'd32,   0,  32'd136, 0};
        vecs[6] = '{32'd200, 64'd2,    1,  32'd2,   1};
        vecs[7] = '{32'd135, 64'd2,    0,  32'd1,   1};
        vecs[8] = '{32'd136, 64'd0,    0,  32'd136, 0};

        reset     = 1'b0;
        rtr       = 1'b0;
        ls_in     = '0;
        pos_in    = '0;
        outlen_in = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset linear_out", lout, '0);
        check_wide("reset state_out", ls_out, '0);
        check("reset pos_out", 256'(pos_out), 256'(0));
        check("reset pulses", 256'({rts, perm_rtr}), 256'(0));
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            base = perm_cnt;
            run_call($sformatf("vec%0d", i), pat, vecs[i].pin, vecs[i].olen, vecs[i].d, a5, 0);
            check($sformatf("vec%0d table_pos", i), 256'(pos_out), 256'(vecs[i].exp_pos));
            check($sformatf("vec%0d table_perms", i), 256'(perm_cnt - base), 256'(vecs[i].exp_perms));
        end

        // rtr pulsed mid-COPY must not disturb the call.
        run_call("glitch", pat, 32'd0, 64'd32, 0, a5, 5);

        // Randomized calls against the model.
        for (int i = 0; i < 24; i++) begin
            rp = ($urandom_range(0, 3) == 0) ? 32'(136 - $urandom_range(0, 2) + $urandom_range(0, 6))
                                             : 32'($urandom_range(0, 136));
            ro = ($urandom_range(0, 7) == 0) ? {32'($urandom), 32'($urandom)}
                                             : 64'($urandom_range(0, 34));
            run_call($sformatf("rand%0d", i), random_state(), rp, ro,
                     $urandom_range(0, 5), random_state(), 0);
        end

        // Reset while waiting on the core: abort, ignore the late perm_rts.
        core_delay = 20;
        perm_val   = a5;
        @(posedge clock);
        #1;
        ls_in     = pat;
        pos_in    = 32'd130;
        outlen_in = 64'd10;
        rtr       = 1'b1;
        @(posedge clock);
        #1 rtr = 1'b0;
        seen = 0;
        for (int c = 0; c < 60 && seen == 0; c++) begin
            @(negedge clock);
            if (perm_rtr === 1'b1) seen = 1;
        end
        check("abort reached perm_req", 256'(seen), 256'(1));
        repeat (4) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        check("abort linear_out", lout, '0);
        check_wide("abort state_out", ls_out, '0);
        check_wide("abort perm_s_out", perm_s_out, '0);
        check("abort pos_out", 256'(pos_out), 256'(0));
        check("abort pulses", 256'({rts, perm_rtr}), 256'(0));
        @(posedge clock);
        #1 reset = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            if (rts === 1'b1 || perm_rtr === 1'b1) seen++;
        end
        check("abort late perm_rts ignored", 256'(seen), 256'(0));
        check("abort pos_out after core", 256'(pos_out), 256'(0));
        check_wide("abort state after core", ls_out, '0);
        run_call("after_abort", pat, 32'd0, 64'd5, 0, a5, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shake256_squeeze.md
Name: shake256_squeeze

Overview:
- Squeeze-side counterpart to the SHAKE256 absorb stage: extracts up to out_len output bytes from a 1600-bit Keccak state at rate 136 bytes.
- Starts at the current rate position and copies one byte per cycle.
- When the rate block is exhausted, requests a Keccak-f[1600] permutation from an external permutation core over a request/acknowledge handshake.
- Returns the updated state and position so successive squeeze calls chain. Used downstream of absorb/finalize in key generation (seed expansion, rho/rho'/K derivation).

Parameters:
- out_len, 32, maximum output bytes per call; linear_out width is out_len*8.
- SHAKE256_RATE (localparam), 136, rate in bytes.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- rtr  input  1  start pulse; sampled only in IDLE.
- linear_state_s_in  input  1600  Keccak state; byte k = bits [8k+7:8k].
- state_pos_in  input  32  current byte position in the rate block, 0..136.
- outlen  input  64  bytes requested; values > out_len are clamped to out_len.
- linear_out  output  out_len*8  squeezed bytes; output byte j = bits [8j+7:8j].
- linear_state_s_out  output  1600  state after squeeze.
- state_pos_out  output  32  position after squeeze.
- rts  output  1  one-cycle done pulse.
- perm_rtr  output  1  one-cycle permutation request.
- perm_linear_s_out  output  1600  state handed to the permutation core.
- perm_linear_s_in  input  1600  permuted state from the core.
- perm_rts  input  1  permutation done; perm_linear_s_in is valid in the same cycle.

Behaviour:
- Reset (reset=0, asynchronous):
  - State machine goes to IDLE.
  - linear_out, linear_state_s_out, state_pos_out and perm_linear_s_out go to 0.
  - rts and perm_rtr go to 0.
  - Reset mid-operation aborts immediately. Any later perm_rts is ignored.
- State machine:
  - IDLE: on rtr=1, latch the state, latch pos = min(state_pos_in, 136), set remaining = min(outlen, out_len), set j = 0, clear linear_out. Go to CHECK. rtr is ignored in all other states.
  - CHECK: if remaining == 0, go to DONE. Else if pos == 136, go to PERM_REQ. Else go to COPY.
  - COPY: each cycle, write linear_out[j] = state byte[pos], then pos += 1, j += 1, remaining -= 1.
    - If remaining reaches 0, go to DONE.
    - Else if pos reaches 136, go to CHECK.
    - Else stay in COPY.
  - PERM_REQ: drive perm_rtr=1 for exactly one cycle with perm_linear_s_out = current state. Go to PERM_WAIT.
  - PERM_WAIT: hold until perm_rts=1. Then load state from perm_linear_s_in, set pos = 0, go to COPY.
  - DONE: rts=1 for one cycle with linear_state_s_out and state_pos_out valid. Go to IDLE.
- Output hold:
  - linear_out, linear_state_s_out and state_pos_out hold their values until the next accepted rtr.
  - linear_out bytes at index >= remaining-at-start stay 0.
- Latency, counting rtr sampled at edge 0:
  - n bytes with no permutation: rts is high in cycle n+2.
  - outlen = 0: rts is high in cycle 2; state and pos pass through unchanged.
  - Each permutation adds 2 cycles plus the core's latency.
- Boundary conditions:
  - state_pos_in = 136 at start: permute before the first byte.
  - The squeeze can end exactly at pos = 136: return pos = 136 and do not permute.
  - At most one permutation per call, since out_len <= 136.
- Arithmetic:
  - pos is a 32-bit counter; it never exceeds 136.
  - remaining and j are sized for out_len.

Test Plan:
- State bytes k = k mod 256, pos = 0, outlen = 32 → linear_out bytes 0x00..0x1F, state_pos_out = 32, state unchanged, rts in cycle 34, perm_rtr never asserted.
- pos = 130, outlen = 10, perm core returns all bytes 0xA5 after 24 cycles → output bytes 130..135 then four 0xA5, state_pos_out = 4, exactly one perm_rtr pulse, perm_linear_s_out equals the input state.
- pos = 136, outlen = 1 → immediate permutation; output byte = permuted byte 0; state_pos_out = 1.
- outlen = 0 and outlen = 1000 (out_len = 32) → first: rts in cycle 2 with pos/state unchanged and linear_out = 0; second: clamped to 32 bytes.
- rtr pulsed again during COPY → ignored; result identical to a single call. pos = 104, outlen = 32 → state_pos_out = 136, no permutation.
- reset dropped in PERM_WAIT → all outputs 0 and IDLE immediately; a following perm_rts has no effect; a fresh rtr completes normally.
